// File: rtl/riscv_run_monitor.sv
// Run controller and self-checker for the pipelined RISC-V core: sequences core reset,
// counts RUN cycles/retirements, detects the halting store, then checks a shadow register file.
module riscv_run_monitor #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TIMEOUT = 250,
  parameter logic [XLEN-1:0] HALT_ADDR = 32'h0000_0FFC,
  parameter int unsigned NCHK = 4,
  localparam int unsigned FIW = (NCHK > 1) ? $clog2(NCHK) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wb_we,
  input  logic [4:0]           wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 retire,
  input  logic                 dmem_we,
  input  logic [XLEN-1:0]      dmem_addr,
  input  logic [XLEN-1:0]      dmem_wdata,
  input  logic [5*NCHK-1:0]    exp_idx,
  input  logic [XLEN*NCHK-1:0] exp_val,
  output logic                 core_reset,
  output logic [31:0]          cycle_count,
  output logic [31:0]          retire_count,
  output logic [XLEN-1:0]      halt_code,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timed_out,
  output logic [FIW-1:0]       fail_idx
);

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_CHECK, S_DONE} state_t;

  localparam logic [FIW-1:0] LAST_IDX = FIW'(NCHK - 1);

  state_t          state;
  logic [31:0]     hold_cnt;
  logic [XLEN-1:0] shadow [32];
  logic [FIW-1:0]  chk_idx;
  logic            mismatch;

  logic            halt_hit;
  logic [4:0]      cur_idx;
  logic [XLEN-1:0] cur_exp;
  logic [XLEN-1:0] cur_act;
  logic            cur_miss;
  logic            any_miss;

  assign halt_hit = dmem_we && (dmem_addr == HALT_ADDR);

  // Select the check currently being evaluated; x0 always reads as zero.
  always_comb begin
    cur_idx = '0;
    cur_exp = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (chk_idx == FIW'(i)) begin
        cur_idx = exp_idx[5*i +: 5];
        cur_exp = exp_val[XLEN*i +: XLEN];
      end
    end
    cur_act  = (cur_idx == 5'd0) ? '0 : shadow[cur_idx];
    cur_miss = (cur_act != cur_exp);
    any_miss = mismatch || cur_miss;
  end

  // Shadow register file tracks write-back traffic only while the core runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) shadow[r] <= '0;
    end else if (state == S_RUN && wb_we && wb_rd != 5'd0) begin
      shadow[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_HOLD;
      hold_cnt     <= '0;
      core_reset   <= 1'b1;
      cycle_count  <= '0;
      retire_count <= '0;
      halt_code    <= '0;
      done         <= 1'b0;
      pass         <= 1'b0;
      fail         <= 1'b0;
      timed_out    <= 1'b0;
      fail_idx     <= '0;
      chk_idx      <= '0;
      mismatch     <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 32'd1;
          if (hold_cnt == 32'(RST_CYCLES - 1)) begin
            state      <= S_RUN;
            core_reset <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_count  <= cycle_count + 32'd1;
          retire_count <= retire_count + {31'd0, retire};
          // A halt on the final allowed cycle still goes to CHECK.
          if (halt_hit) begin
            halt_code  <= dmem_wdata;
            state      <= S_CHECK;
            core_reset <= 1'b1;
          end else if (cycle_count == 32'(TIMEOUT - 1)) begin
            state      <= S_DONE;
            core_reset <= 1'b1;
            done       <= 1'b1;
            fail       <= 1'b1;
            timed_out  <= 1'b1;
          end
        end
        S_CHECK: begin
          if (cur_miss && !mismatch) begin
            mismatch <= 1'b1;
            fail_idx <= chk_idx;
          end
          if (chk_idx == LAST_IDX) begin
            state <= S_DONE;
            done  <= 1'b1;
            pass  <= !any_miss && (halt_code == XLEN'(1));
            fail  <= !(!any_miss && (halt_code == XLEN'(1)));
          end else begin
            chk_idx <= chk_idx + FIW'(1);
          end
        end
        S_DONE: begin
          core_reset <= 1'b1;
        end
        default: state <= S_HOLD;
      endcase
    end
  end

endmodule
